// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full_adder cell, fed LSB-first, carry held in a flop.
// Operands are captured on start; Sum/Cout update only on completion.

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);
   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
   logic             w_s;
   logic             w_co;
   logic             w_last;

   full_adder u_fa (
      .i_a    (r_sh_a[0]),
      .i_b    (r_sh_b[0]),
      .i_cin  (r_carry),
      .o_sum  (w_s),
      .o_cout (w_co)
   );

   // Sum bits enter at the MSB so the LSB-first stream lands in place.
   generate
      if (WIDTH == 1) begin : g_acc1
         assign w_acc_nxt = w_s;
      end else begin : g_accn
         assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};
      end
   endgenerate

   assign w_last = (r_cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_a  <= '0;
         r_sh_b  <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sh_a  <= A;
                  r_sh_b  <= B;
                  r_carry <= Cin;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               r_sh_a  <= r_sh_a >> 1;
               r_sh_b  <= r_sh_b >> 1;
               r_acc   <= w_acc_nxt;
               r_carry <= w_co;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_sum  <= w_acc_nxt;
                  r_cout <= w_co;
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign Sum  = r_sum;
   assign Cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH 8, 1 and 16.
// Expected {Cout,Sum} and done cycle are queued at start, checked on done.

module tb_bit_serial_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [32:0] r;
      int          t;
   } exp_t;

   exp_t q8[$];
   exp_t q1[$];
   exp_t q16[$];
   exp_t e8, e1, e16;

   int errors = 0;
   int checks = 0;

   logic        s8 = 0, c8 = 0, busy8, done8, cout8;
   logic [7:0]  a8 = 0, b8 = 0, sum8;
   logic        s1 = 0, c1 = 0, busy1, done1, cout1;
   logic [0:0]  a1 = 0, b1 = 0, sum1;
   logic        s16 = 0, c16 = 0, busy16, done16, cout16;
   logic [15:0] a16 = 0, b16 = 0, sum16;

   bit_serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(s8), .A(a8), .B(b8), .Cin(c8),
      .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
   );
   bit_serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(s1), .A(a1), .B(b1), .Cin(c1),
      .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1)
   );
   bit_serial_adder #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(s16), .A(a16), .B(b16), .Cin(c16),
      .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   logic pd8 = 0, pd1 = 0, pd16 = 0;

   always @(negedge clk) begin
      if (pd8) check("done8_pulse", done8, 0);
      pd8 = done8;
      if (done8) begin
         if (q8.size() == 0) check("done8_spur", done8, 0);
         else begin
            e8 = q8.pop_front();
            check("res8", {cout8, sum8}, e8.r);
            check("lat8", cyc, e8.t);
         end
      end
   end

   always @(negedge clk) begin
      if (pd1) check("done1_pulse", done1, 0);
      pd1 = done1;
      if (done1) begin
         if (q1.size() == 0) check("done1_spur", done1, 0);
         else begin
            e1 = q1.pop_front();
            check("res1", {cout1, sum1}, e1.r);
            check("lat1", cyc, e1.t);
         end
      end
   end

   always @(negedge clk) begin
      if (pd16) check("done16_pulse", done16, 0);
      pd16 = done16;
      if (done16) begin
         if (q16.size() == 0) check("done16_spur", done16, 0);
         else begin
            e16 = q16.pop_front();
            check("res16", {cout16, sum16}, e16.r);
            check("lat16", cyc, e16.t);
         end
      end
   end

   task automatic go8(input logic [7:0] a, input logic [7:0] b,
                      input logic c);
      exp_t x;
      int n = 0;
      while ((busy8 || done8) && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("idle8_tmo", busy8 | done8, 0);
      a8 = a; b8 = b; c8 = c; s8 = 1;
      x.r = 33'(a) + 33'(b) + 33'(c);
      x.t = cyc + 1 + 8;
      q8.push_back(x);
      @(negedge clk);
      s8 = 0;
   endtask

   task automatic go1(input logic [0:0] a, input logic [0:0] b,
                      input logic c);
      exp_t x;
      int n = 0;
      while ((busy1 || done1) && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("idle1_tmo", busy1 | done1, 0);
      a1 = a; b1 = b; c1 = c; s1 = 1;
      x.r = 33'(a) + 33'(b) + 33'(c);
      x.t = cyc + 1 + 1;
      q1.push_back(x);
      @(negedge clk);
      s1 = 0;
   endtask

   task automatic go16(input logic [15:0] a, input logic [15:0] b,
                       input logic c);
      exp_t x;
      int n = 0;
      while ((busy16 || done16) && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("idle16_tmo", busy16 | done16, 0);
      a16 = a; b16 = b; c16 = c; s16 = 1;
      x.r = 33'(a) + 33'(b) + 33'(c);
      x.t = cyc + 1 + 16;
      q16.push_back(x);
      @(negedge clk);
      s16 = 0;
   endtask

   task automatic waitdone8();
      int n = 0;
      while (!done8 && n < 100) begin @(negedge clk); n++; end
      if (!done8) check("done8_tmo", done8, 1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((q8.size() + q1.size() + q16.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, q8.size() + q1.size() + q16.size(), 0);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_sum", sum8, 0);
      check("rst_cout", cout8, 0);
      rst = 0;
      @(negedge clk);

      // basic add and busy length
      go8(8'h5A, 8'h33, 0);
      n = 0;
      while (!done8 && n < 20) begin
         if (busy8) n++;
         @(negedge clk);
      end
      check("busy8_len", n, 8);
      check("basic_sum", sum8, 8'h8D);
      drain("drain_basic");

      go8(8'hFF, 8'h01, 0);
      go8(8'hFF, 8'hFF, 1);
      drain("drain_ripple");
      check("ripple_cout", cout8, 1);

      // start and operand changes during RUN are ignored
      go8(8'h10, 8'h20, 0);
      @(negedge clk);
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; s8 = 1;
      waitdone8();
      check("ign_sum", sum8, 8'h30);
      s8 = 0;
      repeat (4) @(negedge clk);
      check("ign_norestart", busy8, 0);
      drain("drain_ign");

      // back-to-back with start held high
      a8 = 8'h01; b8 = 8'h01; c8 = 1; s8 = 1;
      for (int i = 0; i < 4; i++) begin
         exp_t x;
         x.r = 33'h3;
         x.t = cyc + 1 + 8 + 10 * i;
         q8.push_back(x);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         waitdone8();
         if (i == 1) begin
            repeat (4) @(negedge clk);
            check("hold_sum", sum8, 8'h03);
         end
      end
      s8 = 0;
      repeat (5) @(negedge clk);
      check("idle_hold", sum8, 8'h03);
      drain("drain_b2b");

      // asynchronous reset mid-RUN
      go8(8'hAA, 8'h55, 1);
      repeat (3) @(posedge clk);
      #2;
      q8.delete();
      rst = 1;
      #1;
      check("mid_rst_busy", busy8, 0);
      check("mid_rst_done", done8, 0);
      check("mid_rst_sum", sum8, 0);
      check("mid_rst_cout", cout8, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (12) @(negedge clk);
      check("post_rst_sum", sum8, 0);
      go8(8'h01, 8'h02, 0);
      drain("drain_rst");
      check("post_rst_add", sum8, 8'h03);

      for (int i = 0; i < 1000; i++)
         go16(16'($urandom), 16'($urandom), 1'($urandom));
      drain("drain16");

      for (int i = 0; i < 1000; i++)
         go1(1'($urandom), 1'($urandom), 1'($urandom));
      drain("drain1");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-bit adder that processes one bit pair per clock through a single full_adder instance.
- Carry is held in a flip-flop between cycles.
- Sits directly around the existing 1-bit full_adder cell: it feeds the cell LSB-first and collects its Sum/Cout.
- Area-minimal alternative to a ripple-carry array; operands are captured by a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request an add; sampled only in IDLE
- A  input  WIDTH  first operand; captured on the accepted start edge
- B  input  WIDTH  second operand; captured on the accepted start edge
- Cin  input  1  carry-in; captured on the accepted start edge
- busy  output  1  high while an add is in progress (RUN)
- done  output  1  one-cycle pulse when Sum/Cout become valid
- Sum  output  WIDTH  registered result; held until the next completion
- Cout  output  1  registered final carry; held until the next completion

Behaviour:
- Clock/reset: one clock (clk). rst is asynchronous, active-high.
- Reset values: state=IDLE; busy=0, done=0, Sum=0, Cout=0. Internal shift registers, carry flop and bit counter are all cleared.
- States: IDLE, RUN, DONE.
- IDLE -> RUN, on a rising edge with start=1:
  - load shA<=A, shB<=B, carry<=Cin, acc<=0, cnt<=0.
  - busy goes 1 from the next cycle.
- RUN, each edge:
  - full_adder inputs are shA[0], shB[0], carry.
  - Shift shA and shB right by 1 with zero fill.
  - Shift the cell's Sum into acc from the MSB side (acc <= {s, acc[WIDTH-1:1]}).
  - carry<=cell Cout; cnt<=cnt+1.
- RUN -> DONE, on the edge where cnt==WIDTH-1, i.e. the WIDTH-th RUN edge:
  - Sum<={s, acc[WIDTH-1:1]}, Cout<=cell Cout.
  - busy<=0, done<=1.
- DONE -> IDLE unconditionally on the next edge; done<=0.
- Latency: start accepted at edge k; done is high in the cycle following edge k+WIDTH (exactly one cycle). Sum/Cout are valid from that same cycle.
- Throughput: one add per WIDTH+2 cycles. A start held continuously is re-accepted on the edge after DONE->IDLE.
- start in RUN or DONE is ignored: no restart, no operand capture. A, B and Cin may change freely after acceptance.
- Sum/Cout change only on the completion edge. They are never exposed mid-computation and are held indefinitely in IDLE.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1), unsigned.
- WIDTH=1: RUN lasts exactly one edge; the transition rule is unchanged.
- Counter width is clog2(WIDTH); for WIDTH=1 the counter is 1 bit and the compare is against 0.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values. The pending result is discarded (Sum/Cout return to 0, no done pulse).
- Reset released with start=1: start is sampled on the first clock edge after release.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Basic add, WIDTH=8: A=8'h5A, B=8'h33, Cin=0, start pulsed one cycle -> busy high for 8 cycles; done high exactly one cycle, 8 cycles after the start edge; Sum=8'h8D, Cout=0.
- Full carry ripple, WIDTH=8: A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1. Then A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1.
- Operand change and start during RUN: start with A=8'h10, B=8'h20, Cin=0. On cycle 3 of RUN, drive A=8'hFF, B=8'hFF, start=1 -> ignored; result Sum=8'h30, Cout=0; exactly one done pulse.
- Back-to-back: start held high continuously with A=8'h01, B=8'h01, Cin=1 -> done pulses every 10 cycles, each giving Sum=8'h03, Cout=0. Sum holds between pulses.
- Reset mid-operation: start A=8'hAA, B=8'h55, Cin=1; assert rst asynchronously (off the clock edge) on RUN cycle 4 -> busy, done, Sum and Cout go 0 immediately, with no done pulse. After release, a new add of 8'h01+8'h02+0 gives Sum=8'h03, Cout=0.
- Random regression at WIDTH=1 and WIDTH=16: 1000 random {A,B,Cin} -> {Cout,Sum} equals A+B+Cin; done latency is exactly WIDTH cycles for every add.
